// File: rtl/prj_processor_switch_debounce.sv
`default_nettype none
//==============================================================================
// Module      : prj_processor_switch_debounce
// Description : Synchronises and debounces each slide-switch bit independently.
//               Drives a clean level bus for the PIO in_port, plus one-cycle
//               per-bit change and rise pulses for interrupt/edge use.
// Revision    : 1.0 - initial release
//==============================================================================
module prj_processor_switch_debounce #(
  parameter int WIDTH         = 9,
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 500000,
  parameter int CNT_W         = 20
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw_clean,
  output logic [WIDTH-1:0] sw_changed,
  output logic [WIDTH-1:0] sw_rise
);

  // Terminal count: a new level is accepted on the edge that finds the
  // counter here, which makes the hold time exactly STABLE_CYCLES samples.
  localparam logic [CNT_W-1:0] c_cnt_max = CNT_W'(STABLE_CYCLES - 1);

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    logic [SYNC_STAGES-1:0] r_sync_chain;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_clean;
    logic                   r_changed;
    logic                   r_rise;
    logic                   w_sync;
    logic                   w_mismatch;
    logic                   w_commit;

    assign w_sync     = r_sync_chain[SYNC_STAGES-1];
    assign w_mismatch = (w_sync != r_clean);
    assign w_commit   = w_mismatch && (r_cnt == c_cnt_max);

    // Metastability synchroniser: shift the raw pin through the flop chain.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        r_sync_chain <= '0;
      end else begin
        r_sync_chain <= {r_sync_chain[SYNC_STAGES-2:0], sw_raw[gi]};
      end
    end

    // Stability counter: counts consecutive mismatching samples, cleared on
    // any return to the current level and on commit, so it never wraps.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        r_cnt <= '0;
      end else if (!w_mismatch || w_commit) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end

    // Clean level and one-cycle pulses, all updated on the commit edge.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        r_clean   <= 1'b0;
        r_changed <= 1'b0;
        r_rise    <= 1'b0;
      end else begin
        r_changed <= w_commit;
        r_rise    <= w_commit && w_sync;
        if (w_commit) begin
          r_clean <= w_sync;
        end
      end
    end

    assign sw_clean[gi]   = r_clean;
    assign sw_changed[gi] = r_changed;
    assign sw_rise[gi]    = r_rise;
  end : g_bit

endmodule
`default_nettype wire
